// File: rtl/path_open_list_pq.sv
// path_open_list_pq: open-list priority queue for A* search, kept sorted by ascending f = g + h.
// Ports: system1000/system1000_rstn are the clock and the async active-low reset.
//   in_*: command handshake (op 00 insert, 01 pop, 10 clear, 11 no-op) and the record to insert.
//   out_*: one-entry buffer holding the popped record.
//   count/empty/full: occupancy. err_drop/err_underflow: one-cycle error pulses.
// Optional feature: define PQ_UPDATE_EN to enable decrease-key on a matching id.
module path_open_list_pq #(
  parameter int DEPTH = 4,
  parameter int KW = 16,
  parameter int IW = 16
) (
  input  logic                         system1000,
  input  logic                         system1000_rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [IW-1:0]                in_id,
  input  logic [KW-1:0]                in_g,
  input  logic [KW-1:0]                in_h,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IW-1:0]                out_id,
  output logic [KW-1:0]                out_g,
  output logic [KW-1:0]                out_h,
  output logic [KW-1:0]                out_f,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         err_drop,
  output logic                         err_underflow
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
    logic [KW-1:0] g;
    logic [KW-1:0] h;
    logic [KW-1:0] f;
  } rec_t;
  localparam rec_t EMPTY = '{v: 1'b0, id: '0, g: {{(KW-1){1'b1}}, 1'b0},
                             h: {{(KW-1){1'b1}}, 1'b0}, f: {1'b0, {(KW-1){1'b1}}}};
  rec_t r_q [DEPTH];
  rec_t w_nq [DEPTH];
  rec_t w_new;
  logic [CW-1:0] r_cnt;
  logic r_ov, r_drop, r_uf;
  logic [IW-1:0] r_oid;
  logic [KW-1:0] r_og, r_oh, r_of;
  logic [KW:0] w_sum;
  logic [KW-1:0] w_f;
  logic w_idle, w_acc, w_clr, w_pop_ok, w_do_ins, w_do_rm, w_full;
  logic [DEPTH-1:0] w_after, w_mask;
  assign w_sum = {1'b0, in_g} + {1'b0, in_h};
  assign w_f = w_sum[KW] ? '1 : w_sum[KW-1:0];
  assign w_full = r_cnt == CW'(DEPTH);
  assign in_ready = w_idle && (!r_ov || out_ready);
  assign w_acc = in_valid && in_ready;
  assign w_clr = w_acc && in_op == 2'b10;
  assign w_pop_ok = w_acc && in_op == 2'b01 && r_cnt != '0;
`ifdef PQ_UPDATE_EN
  typedef enum logic {IDLE, UPD} state_t;
  state_t r_state;
  rec_t r_p;
  logic [DEPTH-1:0] w_match, w_pre;
  logic [KW-1:0] w_mf;
  logic w_hit, w_dec;
  assign w_idle = r_state == IDLE;
  // In UPD the held record is re-inserted after its old copy was removed
  assign w_new = (r_state == UPD) ? r_p : '{1'b1, in_id, in_g, in_h, w_f};
  for (genvar m = 0; m < DEPTH; m++) begin : g_m
    assign w_match[m] = r_q[m].v && r_q[m].id == in_id;
  end
  // w_pre marks the matching entry and everything after it, i.e. the slots that shift up on removal
  always_comb begin
    logic h;
    h = 1'b0;
    w_mf = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[i] && !h) w_mf = r_q[i].f;
      h = h | w_match[i];
      w_pre[i] = h;
    end
    w_hit = h;
  end
  assign w_dec = w_acc && in_op == 2'b00 && w_hit && w_f < w_mf;
  assign w_do_ins = (w_acc && in_op == 2'b00 && !w_hit) || r_state == UPD;
  assign w_do_rm = w_pop_ok || w_dec;
  assign w_mask = w_pop_ok ? '1 : w_pre;
`else
  assign w_idle = 1'b1;
  assign w_new = '{1'b1, in_id, in_g, in_h, w_f};
  assign w_do_ins = w_acc && in_op == 2'b00;
  assign w_do_rm = w_pop_ok;
  assign w_mask = '1;
`endif
  // Valid entries are sorted, so w_after is a thermometer code starting at the insert slot
  for (genvar e = 0; e < DEPTH; e++) begin : g_e
    rec_t w_dn, w_up;
    assign w_after[e] = !r_q[e].v || r_q[e].f > w_new.f;
    if (e == 0) begin : g_first
      assign w_dn = w_new;
    end else begin : g_rest
      assign w_dn = w_after[e-1] ? r_q[e-1] : w_new;
    end
    if (e == DEPTH-1) begin : g_last
      assign w_up = EMPTY;
    end else begin : g_mid
      assign w_up = r_q[e+1];
    end
    assign w_nq[e] = w_clr ? EMPTY :
                     w_do_rm ? (w_mask[e] ? w_up : r_q[e]) :
                     (w_do_ins && w_after[e]) ? w_dn : r_q[e];
  end
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= EMPTY;
      r_cnt <= '0;
      r_ov <= 1'b0;
      r_oid <= '0;
      r_og <= '0;
      r_oh <= '0;
      r_of <= '0;
      r_drop <= 1'b0;
      r_uf <= 1'b0;
`ifdef PQ_UPDATE_EN
      r_state <= IDLE;
      r_p <= '0;
`endif
    end else begin
      r_q <= w_nq;
      r_cnt <= w_clr ? '0 : w_do_rm ? r_cnt - CW'(1) : (w_do_ins && !w_full) ? r_cnt + CW'(1) : r_cnt;
      r_drop <= w_do_ins && w_full;
      r_uf <= w_acc && in_op == 2'b01 && r_cnt == '0;
      if (w_pop_ok) begin
        r_ov <= 1'b1;
        r_oid <= r_q[0].id;
        r_og <= r_q[0].g;
        r_oh <= r_q[0].h;
        r_of <= r_q[0].f;
      end else if (out_ready) begin
        r_ov <= 1'b0;
      end
`ifdef PQ_UPDATE_EN
      r_state <= w_dec ? UPD : IDLE;
      if (w_dec) r_p <= w_new;
`endif
    end
  end
  assign out_valid = r_ov;
  assign out_id = r_oid;
  assign out_g = r_og;
  assign out_h = r_oh;
  assign out_f = r_of;
  assign count = r_cnt;
  assign empty = r_cnt == '0;
  assign full = w_full;
  assign err_drop = r_drop;
  assign err_underflow = r_uf;
endmodule

// File: tb/tb_path_open_list_pq.sv
// tb_path_open_list_pq: scoreboard bench for the sorted open-list priority queue
module tb_path_open_list_pq;
  localparam int DEPTH = 4;
  localparam int KW = 16;
  localparam int IW = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [1:0] in_op = 2'b11;
  logic [IW-1:0] in_id = '0, out_id;
  logic [KW-1:0] in_g = '0, in_h = '0, out_g, out_h, out_f;
  logic [2:0] count;
  logic empty, full, err_drop, err_underflow;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [IW-1:0] id;
    logic [KW-1:0] g;
    logic [KW-1:0] h;
    logic [KW-1:0] f;
  } exp_t;
  exp_t sb[$];
  path_open_list_pq #(.DEPTH(DEPTH), .KW(KW), .IW(IW)) dut (
    .system1000(clk), .system1000_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_id(in_id), .in_g(in_g), .in_h(in_h),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_g(out_g), .out_h(out_h), .out_f(out_f),
    .count(count), .empty(empty), .full(full),
    .err_drop(err_drop), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic cmd(input logic [1:0] op, input logic [IW-1:0] id, input logic [KW-1:0] g, input logic [KW-1:0] h);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_id = id;
    in_g = g;
    in_h = h;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL cmd_timeout op=%0d in_ready stayed 0", op);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 2'b11;
  endtask
  task automatic ins(input logic [IW-1:0] id, input logic [KW-1:0] g, input logic [KW-1:0] h);
    cmd(2'b00, id, g, h);
  endtask
  task automatic pop_exp(input logic [IW-1:0] id, input logic [KW-1:0] g, input logic [KW-1:0] h, input logic [KW-1:0] f);
    exp_t x;
    x.id = id;
    x.g = g;
    x.h = h;
    x.f = f;
    sb.push_back(x);
    cmd(2'b01, '0, '0, '0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out got id=%0h f=%0h want nothing", out_id, out_f);
        end else begin
          x = sb.pop_front();
          chk("out_id", 32'(out_id), 32'(x.id));
          chk("out_g", 32'(out_g), 32'(x.g));
          chk("out_h", 32'(out_h), 32'(x.h));
          chk("out_f", 32'(out_f), 32'(x.f));
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_f", 32'(out_f), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_errs", 32'({err_drop, err_underflow}), 0);
    // sorting with FIFO tie-break
    ins(1, 5, 3);
    ins(2, 1, 1);
    ins(3, 4, 4);
    chk("t1_count", 32'(count), 3);
    chk("t1_err_drop", 32'(err_drop), 0);
    pop_exp(2, 1, 1, 2);
    pop_exp(1, 5, 3, 8);
    pop_exp(3, 4, 4, 8);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_errs", 32'({err_drop, err_underflow}), 0);
    // overflow handling
    ins(10, 10, 0);
    ins(11, 20, 0);
    ins(12, 30, 0);
    ins(13, 40, 0);
    chk("t2_full", 32'(full), 1);
    chk("t2_drop_idle", 32'(err_drop), 0);
    ins(14, 15, 0);
    chk("t2_drop_replace", 32'(err_drop), 1);
    chk("t2_count_replace", 32'(count), 4);
    tick();
    chk("t2_drop_pulse_end", 32'(err_drop), 0);
    ins(15, 50, 0);
    chk("t2_drop_new", 32'(err_drop), 1);
    chk("t2_count_new", 32'(count), 4);
    pop_exp(10, 10, 0, 10);
    pop_exp(14, 15, 0, 15);
    pop_exp(11, 20, 0, 20);
    pop_exp(12, 30, 0, 30);
    chk("t2_empty", 32'(empty), 1);
    // saturation of f
    ins(16, 16'hFFF0, 16'h0100);
    pop_exp(16, 16'hFFF0, 16'h0100, 16'hFFFF);
    // underflow
    tick();
    cmd(2'b01, '0, '0, '0);
    chk("t3_underflow", 32'(err_underflow), 1);
    chk("t3_out_valid", 32'(out_valid), 0);
    chk("t3_count", 32'(count), 0);
    tick();
    chk("t3_underflow_end", 32'(err_underflow), 0);
    // backpressure and throughput
    ins(21, 1, 0);
    ins(22, 2, 0);
    ins(23, 3, 0);
    out_ready = 1'b0;
    pop_exp(21, 1, 0, 1);
    chk("t4_out_valid", 32'(out_valid), 1);
    chk("t4_in_ready_low", 32'(in_ready), 0);
    tick();
    tick();
    chk("t4_held_id", 32'(out_id), 21);
    chk("t4_held_f", 32'(out_f), 1);
    chk("t4_still_blocked", 32'(in_ready), 0);
    out_ready = 1'b1;
    pop_exp(22, 2, 0, 2);
    pop_exp(23, 3, 0, 3);
    chk("t4_stream_id", 32'(out_id), 23);
    chk("t4_count", 32'(count), 0);
    tick();
`ifdef PQ_UPDATE_EN
    ins(7, 10, 10);
    ins(7, 3, 2);
    chk("t5_upd_in_ready", 32'(in_ready), 0);
    tick();
    chk("t5_upd_done", 32'(in_ready), 1);
    chk("t5_count", 32'(count), 1);
    chk("t5_no_drop", 32'(err_drop), 0);
    pop_exp(7, 3, 2, 5);
    ins(7, 3, 2);
    ins(7, 9, 9);
    chk("t5_discard_ready", 32'(in_ready), 1);
    chk("t5_discard_count", 32'(count), 1);
    chk("t5_discard_drop", 32'(err_drop), 0);
    pop_exp(7, 3, 2, 5);
`endif
    // clear while a record is presented
    ins(31, 3, 0);
    ins(32, 4, 0);
    ins(33, 5, 0);
    pop_exp(31, 3, 0, 3);
    chk("t6_presented", 32'(out_valid), 1);
    cmd(2'b10, '0, '0, '0);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    cmd(2'b01, '0, '0, '0);
    chk("t6_underflow", 32'(err_underflow), 1);
    // asynchronous reset with out_valid=1
    ins(41, 1, 0);
    ins(42, 2, 0);
    out_ready = 1'b0;
    cmd(2'b01, '0, '0, '0);
    chk("t7_out_valid_pre", 32'(out_valid), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t7_count", 32'(count), 0);
    chk("t7_out_valid", 32'(out_valid), 0);
    chk("t7_out_id", 32'(out_id), 0);
    chk("t7_empty", 32'(empty), 1);
    chk("t7_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    tick();
`ifdef PQ_UPDATE_EN
    ins(50, 10, 10);
    ins(50, 1, 1);
    chk("t7_in_upd", 32'(in_ready), 0);
    #2 rstn = 1'b0;
    #1;
    chk("t7_upd_ready", 32'(in_ready), 1);
    chk("t7_upd_count", 32'(count), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    chk("t7_upd_no_partial", 32'(count), 0);
`endif
    cmd(2'b01, '0, '0, '0);
    chk("t7_post_underflow", 32'(err_underflow), 1);
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
